wb_message_master: RTL

Bus-side sequencer for the PACKET2MESSAGE stage queue. Acquires the WISHBONE bus when the queue head holds a message, then runs single or incrementing-burst write/read cycles beat by beat. Drives the queue's next_data, retry and message_transmitted handshakes, and handles bus retry, error and timeout. Sits between the message queue and the system WISHBONE interconnect/arbiter.

---
 rtl/wb_message_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wb_message_master.sv
// WISHBONE bus master that drains the PACKET2MESSAGE queue head as single or
// incrementing-burst cycles, with retry backoff, ack timeout and drop-on-error.
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif

module wb_message_master #(
  parameter int unsigned N_BITS_BURST_LENGHT = 7,
  parameter int unsigned N_BITS_TIMEOUT      = 8,
  parameter int unsigned TIMEOUT_CYCLES      = 200,
  parameter int unsigned BACKOFF_CYCLES      = 4,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           r_bus_arbitration_i,
  input  logic [`BUS_ADDRESS_WIDTH-1:0]  address_i,
  input  logic [`BUS_DATA_WIDTH-1:0]     data_i,
  input  logic [`BUS_SEL_WIDTH-1:0]      sel_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           retry_o,
  output logic                           message_transmitted_o,
  output logic                           bus_req_o,
  input  logic                           gnt_i,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [`BUS_ADDRESS_WIDTH-1:0]  adr_o,
  output logic [`BUS_DATA_WIDTH-1:0]     dat_o,
  output logic [`BUS_SEL_WIDTH-1:0]      sel_o,
  output logic [2:0]                     cti_o,
  input  logic                           ack_i,
  input  logic                           rty_i,
  input  logic                           err_i,
  input  logic [`BUS_DATA_WIDTH-1:0]     dat_i,
  output logic [`BUS_DATA_WIDTH-1:0]     read_data_o,
  output logic                           read_valid_o,
  output logic                           error_o
);

  localparam int unsigned AW     = `BUS_ADDRESS_WIDTH;
  localparam int unsigned DW     = `BUS_DATA_WIDTH;
  localparam int unsigned Bytes  = DW / 8;
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 2);
  localparam int unsigned BoW    = $clog2(BACKOFF_CYCLES + 2);
  localparam int unsigned LW     = N_BITS_BURST_LENGHT;

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StBackoff} state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             beat_cnt_q, len_r_q;
  logic                      we_r_q;
  logic [N_BITS_TIMEOUT-1:0] tmo_cnt_q;
  logic [RetryW-1:0]         retry_cnt_q;
  logic [BoW-1:0]            bo_cnt_q;
  logic [DW-1:0]             read_data_q;
  logic                      read_valid_q, error_q;

  logic xfer, last_beat, timeout, term_err, term_rty, term_ack, drop, msg_done;

  // Termination decode, priority err > rty > timeout > ack.
  assign xfer      = (state_q == StXfer);
  assign last_beat = (beat_cnt_q == len_r_q - 1'b1);
  assign timeout   = (tmo_cnt_q == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1));
  assign term_err  = xfer & err_i;
  assign term_rty  = xfer & ~err_i & (rty_i | timeout);
  assign term_ack  = xfer & ~err_i & ~rty_i & ~timeout & ack_i;
  assign drop      = term_rty & (retry_cnt_q == RetryW'(MAX_RETRIES));
  assign msg_done  = term_err | drop | (term_ack & last_beat);

  assign adr_o        = address_i + AW'(beat_cnt_q) * AW'(Bytes);
  assign dat_o        = data_i;
  assign sel_o        = sel_i;
  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;
  assign error_o      = error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (r_bus_arbitration_i) state_d = StReq;
      StReq:     if (gnt_i) state_d = StXfer;
      StXfer: begin
        if (msg_done) begin
          state_d = StIdle;
        end else if (term_rty) begin
          state_d = StBackoff;
        end
      end
      StBackoff: if (bo_cnt_q == BoW'(BACKOFF_CYCLES - 1)) state_d = StReq;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_req_o             = (state_q == StReq) | xfer;
    cyc_o                 = xfer;
    stb_o                 = xfer;
    we_o                  = xfer & we_r_q;
    cti_o                 = 3'b000;
    if (xfer && len_r_q != LW'(1)) begin
      cti_o = last_beat ? 3'b111 : 3'b010;
    end
    next_data_o           = term_ack & ~last_beat;
    retry_o               = term_rty & ~drop;
    message_transmitted_o = msg_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q   <= '0;
      len_r_q      <= '0;
      we_r_q       <= 1'b0;
      tmo_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      bo_cnt_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && r_bus_arbitration_i) begin
        beat_cnt_q <= '0;
        len_r_q    <= burst_lenght_i;
        we_r_q     <= transaction_type_i;
      end else if (term_ack && !last_beat) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end else if (term_rty) begin
        beat_cnt_q <= '0;
      end

      // Held at zero outside XFER so every entry starts a fresh timeout window.
      if (!xfer || term_ack) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      if (msg_done) begin
        retry_cnt_q <= '0;
      end else if (term_rty) begin
        retry_cnt_q <= retry_cnt_q + 1'b1;
      end

      bo_cnt_q <= (state_q == StBackoff) ? bo_cnt_q + 1'b1 : '0;

      read_valid_q <= term_ack & ~we_r_q;
      if (term_ack && !we_r_q) begin
        read_data_q <= dat_i;
      end
      error_q <= term_err | drop;
    end
  end

endmodule
